// File: rtl/serial_add_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// serial_alu_pkg
//   Shared definitions for the bit-serial adder sequencer (serial_add_ctrl).
//   Holds the FSM state type and its encoding constants so that the
//   sequencer and any observer logic agree on the state values.
//
//   Contents:
//     ST_IDLE / ST_RUN / ST_DONE  2-bit encoding constants
//     state_t                     FSM state enum built on those constants
// ----------------------------------------------------------------------------
package serial_alu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl_if
//   Operand/result handshake bundle for serial_add_ctrl.
//
//   Parameter:
//     WIDTH      operand/result width in bits
//
//   Signals:
//     in_valid   producer -> block   operands on A/B/carry_in are valid
//     in_ready   block -> producer   block can accept operands (IDLE only)
//     A, B       producer -> block   WIDTH-bit operands
//     carry_in   producer -> block   initial carry
//     sub        producer -> block   subtract request (only with SERIAL_SUB_EN)
//     out_valid  block -> consumer   sum/carry_out valid
//     out_ready  consumer -> block   consumer accepts result
//     sum        block -> consumer   WIDTH-bit result
//     carry_out  block -> consumer   carry out of bit WIDTH-1
//     busy       block -> anyone     high while RUN or DONE
//
//   Modports:
//     slave   the serial adder block
//     master  the producer/consumer side (testbench or surrounding datapath)
//
//   Optional feature macro: SERIAL_SUB_EN (adds the sub signal).
// ----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             carry_in;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;

    modport slave (
`ifdef SERIAL_SUB_EN
        input  sub,
`endif
        input  in_valid,
        input  A,
        input  B,
        input  carry_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output carry_out,
        output busy
    );

    modport master (
`ifdef SERIAL_SUB_EN
        output sub,
`endif
        output in_valid,
        output A,
        output B,
        output carry_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  carry_out,
        input  busy
    );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// ----------------------------------------------------------------------------
// full_adder
//   1-bit full adder cell used as the arithmetic slice of the bit-serial
//   adder.
//
//   Ports:
//     a, b   in   operand bits
//     cin    in   carry in
//     s      out  sum bit      (a ^ b ^ cin)
//     cout   out  carry out    (majority of a, b, cin)
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl
//   Sequencer for a bit-serial adder built around a single full_adder slice.
//   Operands are accepted through a valid/ready handshake, processed one bit
//   pair per clock (LSB first) with the carry registered between bits, and
//   the result is held until the consumer takes it. An add takes WIDTH
//   cycles; one op completes at most every WIDTH+2 cycles.
//
//   Parameter:
//     WIDTH   operand/result width in bits (>= 2)
//
//   Ports:
//     clk     in   rising-edge clock
//     rst     in   synchronous, active-high reset
//     bus     serial_add_ctrl_if.slave  (in_valid/in_ready/A/B/carry_in/
//             [sub]/out_valid/out_ready/sum/carry_out/busy)
//
//   Optional feature macro: SERIAL_SUB_EN
//     When defined, bus.sub is sampled at accept; sub=1 computes A-B by
//     latching ~B and forcing the initial carry to 1 (carry_in ignored).
//     carry_out=1 then means no borrow (A >= B).
// ----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_add_ctrl_if.slave       bus
);

    localparam int unsigned    CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_n;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;

    logic [WIDTH-1:0] sum_q;
    logic             co_q;
    logic             ov_q;

    logic             accept;
    logic             last_bit;
    logic             release_res;

    logic [WIDTH-1:0] b_init;
    logic             c_init;

    logic             fa_s;
    logic             fa_c;

    // ------------------------------------------------------------------
    // Operand conditioning at accept
    // ------------------------------------------------------------------
`ifdef SERIAL_SUB_EN
    // Two's-complement subtract: A + ~B + 1.
    always_comb begin
        b_init = bus.sub ? ~bus.B : bus.B;
        c_init = bus.sub ? 1'b1   : bus.carry_in;
    end
`else
    always_comb begin
        b_init = bus.B;
        c_init = bus.carry_in;
    end
`endif

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        accept      = (state == IDLE) && bus.in_valid;
        last_bit    = (state == RUN)  && (cnt == CNT_LAST);
        release_res = (state == DONE) && bus.out_ready;
    end

    // ------------------------------------------------------------------
    // 1-bit arithmetic slice
    // ------------------------------------------------------------------
    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept)      state_n = RUN;
            RUN:  if (last_bit)    state_n = DONE;
            DONE: if (release_res) state_n = IDLE;
            default:               state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counter, shift registers, carry flop, result registers
    //
    // a_sh doubles as the sum accumulator: as each operand bit leaves at
    // the LSB, the matching sum bit enters at the MSB, so after WIDTH
    // shifts the register holds the full sum. The final bit is merged
    // directly into sum_q at the last edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            sum_q <= '0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= bus.A;
                        b_sh  <= b_init;
                        carry <= c_init;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= {fa_s, a_sh[WIDTH-1:1]};
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    if (last_bit) begin
                        sum_q <= {fa_s, a_sh[WIDTH-1:1]};
                        co_q  <= fa_c;
                        ov_q  <= 1'b1;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (release_res) begin
                        ov_q <= 1'b0;
                    end
                end
                default: begin
                    ov_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.busy      = (state != IDLE);
        bus.out_valid = ov_q;
        bus.sum       = sum_q;
        bus.carry_out = co_q;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;

    int unsigned n_cmp;
    int unsigned n_err;

`ifdef SERIAL_SUB_EN
    logic sub_req;
`endif

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full transaction: accept, scramble inputs during RUN, measure latency,
    // check the result, then release it.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] exp_s, input logic exp_c);
        int unsigned lat;
        bus.A        = a;
        bus.B        = b;
        bus.carry_in = cin;
`ifdef SERIAL_SUB_EN
        bus.sub      = sub_req;
`endif
        bus.in_valid = 1'b1;
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.A        = 8'($urandom);
        bus.B        = 8'($urandom);
        bus.carry_in = 1'($urandom);
`ifdef SERIAL_SUB_EN
        bus.sub      = ~sub_req;
`endif
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        for (int k = 1; k <= 4 * W; k++) begin
            tick();
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, lat, W);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(exp_s));
        chk({tag, "_co"},  32'(bus.carry_out), 32'(exp_c));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_ovlo"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ra, rb, rbe;
        logic       rc, rce;
        logic [8:0] ref_r;
        int unsigned lat;
        logic [7:0] held_s;
        logic       held_c;

        n_cmp = 0;
        n_err = 0;
`ifdef SERIAL_SUB_EN
        sub_req = 1'b0;
        bus.sub = 1'b0;
`endif
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_sum",  32'(bus.sum), 32'd0);
        chk("rst_co",   32'(bus.carry_out), 32'd0);
        chk("rst_ov",   32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rdy",  32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Directed adds
        run_op("t1", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        run_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("t2b", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        run_op("t2c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        // Result held in IDLE
        tick();
        chk("hold_idle_sum", 32'(bus.sum), 32'hFF);
        chk("hold_idle_co",  32'(bus.carry_out), 32'd1);

        // Backpressure in DONE
        bus.A = 8'h12; bus.B = 8'h34; bus.carry_in = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 4 * W; k++) begin
            tick();
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        chk("bp_lat", lat, W);
        chk("bp_sum0", 32'(bus.sum), 32'h46);
        held_s = bus.sum;
        held_c = bus.carry_out;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = k[0];
            bus.A = 8'hFF; bus.B = 8'hFF; bus.carry_in = 1'b1;
            tick();
            chk("bp_sum",  32'(bus.sum), 32'(held_s));
            chk("bp_co",   32'(bus.carry_out), 32'(held_c));
            chk("bp_ov",   32'(bus.out_valid), 32'd1);
            chk("bp_rdy",  32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_rel_ov", 32'(bus.out_valid), 32'd0);
        chk("bp_rel_rdy", 32'(bus.in_ready), 32'd1);

        // Reset mid-RUN
        bus.A = 8'hAA; bus.B = 8'h55; bus.carry_in = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        chk("mr_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_sum",  32'(bus.sum), 32'd0);
        chk("mr_co",   32'(bus.carry_out), 32'd0);
        chk("mr_ov",   32'(bus.out_valid), 32'd0);
        chk("mr_busy0", 32'(bus.busy), 32'd0);
        chk("mr_rdy",  32'(bus.in_ready), 32'd1);
        run_op("t4", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_SUB_EN
        sub_req = 1'b1;
        run_op("t5a", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        run_op("t5b", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
        sub_req = 1'b0;
`endif

        // Back-to-back with in_valid held high and out_ready high
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rbe = rb;
            rce = rc;
`ifdef SERIAL_SUB_EN
            bus.sub = 1'($urandom);
            if (bus.sub) begin
                rbe = ~rb;
                rce = 1'b1;
            end
`endif
            ref_r = {1'b0, ra} + {1'b0, rbe} + {8'd0, rce};
            bus.A = ra; bus.B = rb; bus.carry_in = rc;
            chk("b2b_rdy", 32'(bus.in_ready), 32'd1);
            tick();
            bus.A = 8'($urandom); bus.B = 8'($urandom); bus.carry_in = 1'($urandom);
            chk("b2b_run", 32'(bus.in_ready), 32'd0);
            lat = 0;
            for (int k = 1; k <= 4 * W; k++) begin
                tick();
                if (bus.out_valid) begin
                    lat = k;
                    break;
                end
            end
            chk("b2b_lat", lat, W);
            chk("b2b_sum", 32'(bus.sum), 32'(ref_r[7:0]));
            chk("b2b_co",  32'(bus.carry_out), 32'(ref_r[8]));
            tick();
            chk("b2b_noq", 32'(bus.busy), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
